// File: rtl/apb_slave_regs_pkg.sv
// Shared APB slave definitions.
// Completer state encoding, register indices and the wait-field width.
package apb_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_READY
  } apb_slv_state_t;

  localparam int IDX_CFG = 0;
  localparam int IDX_ID  = 1;
  localparam int WAIT_W  = 4;

endpackage

// File: rtl/apb_slave_regs_if.sv
// APB bus bundle between master and completer.
// The master drives select/control/data; the completer drives the response.
interface apb_slave_regs_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);

    logic                  pselx;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic                  pready;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pslverr;

    modport master (
        output pselx, penable, pwrite, paddr, pwdata,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  pselx, penable, pwrite, paddr, pwdata,
        output pready, prdata, pslverr
    );

endinterface

// File: rtl/apb_slave_regfile.sv
// CFG / ID / MEM storage with address decode and error detection.
// Decode is combinational on the live bus; writes use the latched index.
module apb_slave_regfile
  import apb_pkg::*;
#(
    parameter int              ADDR_WIDTH   = 32,
    parameter int              DATA_WIDTH   = 32,
    parameter int              DEPTH        = 16,
    parameter int              WAIT_DEFAULT = 2,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE = 32'hA9B0_0001
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic                  pwrite,
    output logic [ADDR_WIDTH-3:0] idx,
    output logic                  err,
    output logic [DATA_WIDTH-1:0] rdata,
    input  logic                  we,
    input  logic [ADDR_WIDTH-3:0] widx,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [WAIT_W-1:0]     wait_cfg
);

    localparam int IW = ADDR_WIDTH - 2;
    localparam int MW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IW-1:0] IDX_MAX = IW'(DEPTH + 1);

    logic [WAIT_W-1:0]     wait_q;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  is_cfg;
    logic                  is_id;
    logic                  is_mem;
    logic [MW-1:0]         rsel;
    logic [MW-1:0]         wsel;

    assign idx      = paddr[ADDR_WIDTH-1:2];
    assign is_cfg   = (idx == IW'(IDX_CFG));
    assign is_id    = (idx == IW'(IDX_ID));
    assign is_mem   = (idx >= IW'(2)) && (idx <= IDX_MAX);
    assign err      = (paddr[1:0] != 2'b00)
                    || (idx > IDX_MAX)
                    || (pwrite && is_id);
    assign rsel     = MW'(idx - IW'(2));
    assign wsel     = MW'(widx - IW'(2));
    assign wait_cfg = wait_q;

    always_comb begin
        rdata = '0;
        unique case (1'b1)
            is_cfg:  rdata = {{(DATA_WIDTH-WAIT_W){1'b0}}, wait_q};
            is_id:   rdata = ID_VALUE;
            is_mem:  rdata = mem[rsel];
            default: rdata = '0;
        endcase
    end

    // we is only raised for non-error writes, so widx is CFG or a MEM slot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_q <= WAIT_W'(WAIT_DEFAULT);
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            if (widx == IW'(IDX_CFG)) begin
                wait_q <= wdata[WAIT_W-1:0];
            end else if (widx >= IW'(2)) begin
                mem[wsel] <= wdata;
            end
        end
    end

endmodule

// File: rtl/apb_slave_regs.sv
// APB completer with programmable wait states over a small register file.
// The FSM latches the transfer at setup and answers after CFG.WAIT cycles.
module apb_slave_regs
  import apb_pkg::*;
#(
    parameter int              ADDR_WIDTH   = 32,
    parameter int              DATA_WIDTH   = 32,
    parameter int              DEPTH        = 16,
    parameter int              WAIT_DEFAULT = 2,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE = 32'hA9B0_0001
) (
    input logic             pclk,
    input logic             preset,
    apb_slave_regs_if.slave bus
);

    apb_slv_state_t        state;
    logic [WAIT_W-1:0]     cnt;
    logic                  wr_q;
    logic                  err_q;
    logic [ADDR_WIDTH-3:0] idx_q;
    logic [DATA_WIDTH-1:0] rd_q;
    logic                  pready_q;
    logic [DATA_WIDTH-1:0] prdata_q;
    logic                  pslverr_q;

    logic [ADDR_WIDTH-3:0] idx;
    logic                  err;
    logic [DATA_WIDTH-1:0] rdata;
    logic [WAIT_W-1:0]     wait_cfg;
    logic                  setup;
    logic                  we;
    logic [DATA_WIDTH-1:0] rd_now;

    assign setup  = bus.pselx && !bus.penable;
    assign we     = (state == S_READY) && wr_q && !err_q;
    assign rd_now = (err || bus.pwrite) ? '0 : rdata;

    assign bus.pready  = pready_q;
    assign bus.prdata  = prdata_q;
    assign bus.pslverr = pslverr_q;

    apb_slave_regfile #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .DATA_WIDTH  (DATA_WIDTH),
        .DEPTH       (DEPTH),
        .WAIT_DEFAULT(WAIT_DEFAULT),
        .ID_VALUE    (ID_VALUE)
    ) u_regfile (
        .clk     (pclk),
        .rst     (preset),
        .paddr   (bus.paddr),
        .pwrite  (bus.pwrite),
        .idx     (idx),
        .err     (err),
        .rdata   (rdata),
        .we      (we),
        .widx    (idx_q),
        .wdata   (bus.pwdata),
        .wait_cfg(wait_cfg)
    );

    // read data is captured at setup so a write never leaks into its own read
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            wr_q      <= 1'b0;
            err_q     <= 1'b0;
            idx_q     <= '0;
            rd_q      <= '0;
            pready_q  <= 1'b0;
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (setup) begin
                        wr_q  <= bus.pwrite;
                        err_q <= err;
                        idx_q <= idx;
                        rd_q  <= rd_now;
                        cnt   <= wait_cfg;
                        if (wait_cfg == '0) begin
                            state     <= S_READY;
                            pready_q  <= 1'b1;
                            prdata_q  <= rd_now;
                            pslverr_q <= err;
                        end else begin
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    cnt <= cnt - WAIT_W'(1);
                    if (!bus.pselx) begin
                        state <= S_IDLE;
                    end else if (cnt == WAIT_W'(1)) begin
                        state     <= S_READY;
                        pready_q  <= 1'b1;
                        prdata_q  <= rd_q;
                        pslverr_q <= err_q;
                    end
                end
                S_READY: begin
                    state     <= S_IDLE;
                    pready_q  <= 1'b0;
                    prdata_q  <= '0;
                    pslverr_q <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_slave_regs.sv
// Bench for apb_slave_regs: vector table, corner sequences, random traffic.
// Random transfers are checked against an array-based register model.
module tb_apb_slave_regs;

    localparam int          DEPTH = 16;
    localparam logic [31:0] IDV   = 32'hA9B0_0001;

    logic pclk = 1'b0;
    logic preset = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [31:0] m_mem [DEPTH];
    int          m_wait;

    always #5 pclk = ~pclk;

    apb_slave_regs_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    apb_slave_regs #(
        .ADDR_WIDTH  (32),
        .DATA_WIDTH  (32),
        .DEPTH       (DEPTH),
        .WAIT_DEFAULT(2),
        .ID_VALUE    (IDV)
    ) dut (
        .pclk  (pclk),
        .preset(preset),
        .bus   (bus.slave)
    );

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        bit          err;
        int          waits;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        m_wait = 2;
    endtask

    task automatic model(input bit wr, input logic [31:0] a,
                         input logic [31:0] d, output logic [31:0] r,
                         output bit e, output int w);
        int idx;
        idx = int'(a >> 2);
        w = m_wait;
        e = (a[1:0] != 2'b00) || (idx > DEPTH + 1) || (wr && idx == 1);
        r = '0;
        if (!e && !wr) begin
            if (idx == 0) r = 32'(m_wait);
            else if (idx == 1) r = IDV;
            else r = m_mem[idx-2];
        end
        if (!e && wr) begin
            if (idx == 0) m_wait = int'(d[3:0]);
            else m_mem[idx-2] = d;
        end
    endtask

    task automatic idle();
        @(posedge pclk); #1;
        bus.pselx   = 1'b0;
        bus.penable = 1'b0;
    endtask

    // One complete master transfer; w counts access cycles with pready low
    task automatic xfer(input bit wr, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] r,
                        output bit e, output int w, output bit quiet);
        @(posedge pclk); #1;
        quiet = !bus.pready && bus.prdata == '0 && !bus.pslverr;
        bus.pselx   = 1'b1;
        bus.penable = 1'b0;
        bus.pwrite  = wr;
        bus.paddr   = a;
        bus.pwdata  = d;
        @(posedge pclk); #1;
        bus.penable = 1'b1;
        w = 0;
        while (!bus.pready && w < 40) begin
            if (bus.prdata != '0 || bus.pslverr) quiet = 1'b0;
            @(posedge pclk); #1;
            w++;
        end
        r = bus.prdata;
        e = bus.pslverr;
    endtask

    task automatic run(input string nm, input bit wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] xr,
                       input bit xe, input int xw);
        logic [31:0] r;
        bit          e;
        bit          q;
        int          w;
        xfer(wr, a, d, r, e, w, q);
        chk({nm, " waits"}, 32'(w), 32'(xw));
        chk({nm, " pslverr"}, 32'(e), 32'(xe));
        if (!wr || xe) chk({nm, " prdata"}, r, xr);
        chk({nm, " idle outputs"}, 32'(q), 32'd1);
    endtask

    task automatic run_model(input string nm, input bit wr,
                             input logic [31:0] a, input logic [31:0] d);
        logic [31:0] xr;
        bit          xe;
        int          xw;
        model(wr, a, d, xr, xe, xw);
        run(nm, wr, a, d, xr, xe, xw);
    endtask

    initial begin
        vec_t        vt [$];
        logic [31:0] mr;
        bit          me;
        int          mw;
        logic [31:0] a;

        bus.pselx   = 1'b0;
        bus.penable = 1'b0;
        bus.pwrite  = 1'b0;
        bus.paddr   = '0;
        bus.pwdata  = '0;
        model_reset();
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        preset = 1'b0;
        #1;
        chk("reset pready", 32'(bus.pready), 32'd0);
        chk("reset prdata", bus.prdata, 32'd0);
        chk("reset pslverr", 32'(bus.pslverr), 32'd0);

        vt.push_back('{0, 32'h04, 32'h0,         IDV,          0, 2});
        vt.push_back('{1, 32'h00, 32'h0,         32'h0,        0, 2});
        vt.push_back('{1, 32'h08, 32'hDEADBEEF,  32'h0,        0, 0});
        vt.push_back('{0, 32'h08, 32'h0,         32'hDEADBEEF, 0, 0});
        vt.push_back('{1, 32'h00, 32'h5,         32'h0,        0, 0});
        vt.push_back('{0, 32'h0C, 32'h0,         32'h0,        0, 5});
        vt.push_back('{1, 32'h04, 32'h12345678,  32'h0,        1, 5});
        vt.push_back('{0, 32'h49, 32'h0,         32'h0,        1, 5});
        vt.push_back('{0, 32'h48, 32'h0,         32'h0,        1, 5});
        vt.push_back('{0, 32'h04, 32'h0,         IDV,          0, 5});
        vt.push_back('{0, 32'h00, 32'h0,         32'h5,        0, 5});
        vt.push_back('{1, 32'h44, 32'h0BADF00D,  32'h0,        0, 5});
        vt.push_back('{1, 32'h00, 32'h7,         32'h0,        0, 5});
        vt.push_back('{0, 32'h44, 32'h0,         32'h0BADF00D, 0, 7});
        for (int i = 0; i < vt.size(); i++) begin
            model(vt[i].wr, vt[i].addr, vt[i].wdata, mr, me, mw);
            run($sformatf("vec%0d", i), vt[i].wr, vt[i].addr,
                vt[i].wdata, vt[i].rdata, vt[i].err, vt[i].waits);
        end

        // reset while a write to 0x10 sits in WAIT
        @(posedge pclk); #1;
        bus.pselx   = 1'b1;
        bus.penable = 1'b0;
        bus.pwrite  = 1'b1;
        bus.paddr   = 32'h10;
        bus.pwdata  = 32'hCAFE_F00D;
        @(posedge pclk); #1;
        bus.penable = 1'b1;
        @(posedge pclk); #1;
        preset = 1'b1;
        #1;
        chk("midreset pready", 32'(bus.pready), 32'd0);
        chk("midreset prdata", bus.prdata, 32'd0);
        bus.pselx   = 1'b0;
        bus.penable = 1'b0;
        @(negedge pclk);
        preset = 1'b0;
        model_reset();
        run("after reset mem10", 0, 32'h10, 32'h0, 32'h0, 0, 2);
        run("after reset cfg", 0, 32'h00, 32'h0, 32'h2, 0, 2);

        // master drops pselx during WAIT: no completion, no write
        @(posedge pclk); #1;
        bus.pselx   = 1'b1;
        bus.penable = 1'b0;
        bus.pwrite  = 1'b1;
        bus.paddr   = 32'h14;
        bus.pwdata  = 32'h1234;
        @(posedge pclk); #1;
        bus.penable = 1'b1;
        @(posedge pclk); #1;
        bus.pselx   = 1'b0;
        bus.penable = 1'b0;
        me = 1'b0;
        repeat (4) begin
            if (bus.pready) me = 1'b1;
            @(posedge pclk); #1;
        end
        chk("abort no pready", 32'(me), 32'd0);
        run("abort mem14", 0, 32'h14, 32'h0, 32'h0, 0, 2);

        // stray penable without setup must be ignored
        @(posedge pclk); #1;
        bus.pselx   = 1'b1;
        bus.penable = 1'b1;
        me = 1'b0;
        repeat (4) begin
            @(posedge pclk); #1;
            if (bus.pready) me = 1'b1;
        end
        chk("stray penable", 32'(me), 32'd0);
        idle();

        for (int i = 0; i < 200; i++) begin
            a = 32'($urandom_range(0, DEPTH + 3)) << 2;
            if ($urandom_range(0, 9) == 0) a[1:0] = 2'($urandom_range(1, 3));
            run_model($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)),
                      a, $urandom);
            if ($urandom_range(0, 3) == 0) idle();
        end
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
